// File: rtl/jelly_rasterizer_scan_ctl.sv
// Raster-scan sequencer for the jelly_rasterizer_plane_calc datapath.
// Issues pixels in raster order with x_first/y_first strobes, drives the shared
// calculator cke with sink back-pressure, and carries valid/eol/last through a
// LATENCY-deep shadow pipeline so they line up with the calculator outputs.
//
// Optional build macro:
//   JELLY_RASTERIZER_SCAN_CTL_CONTINUOUS_EN - after the last pixel of a frame is
//   accepted, restart scanning immediately (params re-latched) instead of idling.

module jelly_rasterizer_scan_ctl #(
    parameter int unsigned X_WIDTH = 12,
    parameter int unsigned Y_WIDTH = 12,
    parameter int unsigned LATENCY = 1
) (
    input  logic               reset_n,
    input  logic               clk,

    input  logic               start,
    input  logic               abort,
    input  logic [X_WIDTH-1:0] param_x_last,
    input  logic [Y_WIDTH-1:0] param_y_last,

    output logic               busy,
    output logic               done,

    output logic               cke,
    output logic               calc_valid,
    output logic               calc_x_first,
    output logic               calc_y_first,

    output logic               m_valid,
    output logic               m_eol,
    output logic               m_last,
    input  logic               m_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDrain
    } state_e;

    state_e               state_q, state_d;
    logic [X_WIDTH-1:0]   x_q, x_d;
    logic [Y_WIDTH-1:0]   y_q, y_d;
    logic [X_WIDTH-1:0]   x_last_q, x_last_d;
    logic [Y_WIDTH-1:0]   y_last_q, y_last_d;
    logic                 done_q, done_d;

    logic [LATENCY-1:0]   vld_q, vld_d;
    logic [LATENCY-1:0]   eol_q, eol_d;
    logic [LATENCY-1:0]   lst_q, lst_d;

    logic                 x_end;
    logic                 y_end;
    logic                 accept_last;

    assign x_end       = (x_q == x_last_q);
    assign y_end       = (y_q == y_last_q);
    assign accept_last = m_valid & m_ready & m_last;

    // Sink back-pressure: calculators only advance when the output slot is free or taken.
    assign cke          = ~m_valid | m_ready;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign calc_valid   = (state_q == StScan);
    assign calc_x_first = (x_q == '0);
    assign calc_y_first = (y_q == '0);

    assign m_valid = vld_q[LATENCY-1];
    assign m_eol   = eol_q[LATENCY-1];
    assign m_last  = lst_q[LATENCY-1];

    // Next-state logic for the scan FSM, raster counters and latched frame size.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        x_last_d = x_last_q;
        y_last_d = y_last_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_last_d = param_x_last;
                    y_last_d = param_y_last;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = StScan;
                end
            end
            StScan: begin
                if (cke) begin
                    if (x_end) begin
                        x_d = '0;
                        if (y_end) begin
                            // Park counters at 0 so they never pass the latched last index.
                            y_d     = '0;
                            state_d = StDrain;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (accept_last) begin
                    done_d = 1'b1;
`ifdef JELLY_RASTERIZER_SCAN_CTL_CONTINUOUS_EN
                    x_last_d = param_x_last;
                    y_last_d = param_y_last;
                    x_d      = '0;
                    y_d      = '0;
                    state_d  = StScan;
`else
                    state_d  = StIdle;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides everything, including a coincident start.
        if (abort) begin
            state_d = StIdle;
            x_d     = '0;
            y_d     = '0;
            done_d  = 1'b0;
        end
    end

    // Shadow pipeline of valid/eol/last, shifted only on cke so it tracks the calculators.
    always_comb begin
        vld_d = vld_q;
        eol_d = eol_q;
        lst_d = lst_q;
        if (abort) begin
            vld_d = '0;
            eol_d = '0;
            lst_d = '0;
        end else if (cke) begin
            vld_d[0] = calc_valid;
            eol_d[0] = calc_valid & x_end;
            lst_d[0] = calc_valid & x_end & y_end;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                eol_d[i] = eol_q[i-1];
                lst_d[i] = lst_q[i-1];
            end
        end
    end

    // State, counter, parameter and pipeline registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            x_last_q <= '0;
            y_last_q <= '0;
            done_q   <= 1'b0;
            vld_q    <= '0;
            eol_q    <= '0;
            lst_q    <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            x_last_q <= x_last_d;
            y_last_q <= y_last_d;
            done_q   <= done_d;
            vld_q    <= vld_d;
            eol_q    <= eol_d;
            lst_q    <= lst_d;
        end
    end

endmodule

// File: tb/tb_jelly_rasterizer_scan_ctl.sv
// Self-checking bench for jelly_rasterizer_scan_ctl.
// Expected issue strobes and output beats are queued when a frame is started and
// popped by a negedge monitor as the DUT issues / hands off pixels.

module tb_jelly_rasterizer_scan_ctl;

    localparam int unsigned XW  = 12;
    localparam int unsigned YW  = 12;
    localparam int unsigned LAT = 1;

    logic          reset_n;
    logic          clk;
    logic          start;
    logic          abort;
    logic [XW-1:0] param_x_last;
    logic [YW-1:0] param_y_last;
    logic          busy;
    logic          done;
    logic          cke;
    logic          calc_valid;
    logic          calc_x_first;
    logic          calc_y_first;
    logic          m_valid;
    logic          m_eol;
    logic          m_last;
    logic          m_ready;

    jelly_rasterizer_scan_ctl #(
        .X_WIDTH (XW),
        .Y_WIDTH (YW),
        .LATENCY (LAT)
    ) u_dut (
        .reset_n      (reset_n),
        .clk          (clk),
        .start        (start),
        .abort        (abort),
        .param_x_last (param_x_last),
        .param_y_last (param_y_last),
        .busy         (busy),
        .done         (done),
        .cke          (cke),
        .calc_valid   (calc_valid),
        .calc_x_first (calc_x_first),
        .calc_y_first (calc_y_first),
        .m_valid      (m_valid),
        .m_eol        (m_eol),
        .m_last       (m_last),
        .m_ready      (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // {x_first, y_first} per issued pixel, {eol, last} per output beat
    logic [1:0] iss_q[$];
    logic [1:0] beat_q[$];

    int  cyc = 0;
    int  hs_cnt = 0;
    int  done_cnt = 0;
    int  last_hs_cyc = -1;
    int  done_cyc = -1;
    bit  toggle_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pops on issue and on handshake, plus cke rule.
    always @(negedge clk) begin
        if (reset_n) begin
            check_eq("cke_rule", {31'b0, cke}, {31'b0, (!m_valid) || m_ready});
            if (calc_valid && cke) begin
                if (iss_q.size() == 0) begin
                    check_eq("issue_extra", 32'd1, 32'd0);
                end else begin
                    check_eq("issue_first", {30'b0, calc_x_first, calc_y_first}, {30'b0, iss_q.pop_front()});
                end
            end
            if (m_valid && m_ready) begin
                hs_cnt <= hs_cnt + 1;
                if (m_last) last_hs_cyc <= cyc;
                if (beat_q.size() == 0) begin
                    check_eq("beat_extra", 32'd1, 32'd0);
                end else begin
                    check_eq("beat_flags", {30'b0, m_eol, m_last}, {30'b0, beat_q.pop_front()});
                end
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
`ifndef JELLY_RASTERIZER_SCAN_CTL_CONTINUOUS_EN
                check_eq("busy_at_done", {31'b0, busy}, 32'd0);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (toggle_ready) m_ready = ~m_ready;
    endtask

    task automatic push_frame(input int xl, input int yl);
        for (int y = 0; y <= yl; y++) begin
            for (int x = 0; x <= xl; x++) begin
                iss_q.push_back({x == 0, y == 0});
                beat_q.push_back({x == xl, (x == xl) && (y == yl)});
            end
        end
    endtask

    task automatic pulse_start(input int xl, input int yl);
        param_x_last = XW'(xl);
        param_y_last = YW'(yl);
        push_frame(xl, yl);
        start = 1'b1;
        step();
        start = 1'b0;
        // Mid-frame param changes must not matter.
        param_x_last = XW'(7);
        param_y_last = YW'(7);
    endtask

    task automatic run_frame(input string tag, input int xl, input int yl);
        int h0;
        int d0;
        h0 = hs_cnt;
        d0 = done_cnt;
        pulse_start(xl, yl);
        for (int i = 0; i < 300 && done_cnt == d0; i++) step();
        check_eq({tag, "_done_seen"}, {31'b0, done_cnt != d0}, 32'd1);
        repeat (3) step();
        check_eq({tag, "_beats"}, hs_cnt - h0, (xl + 1) * (yl + 1));
        check_eq({tag, "_done_once"}, done_cnt - d0, 32'd1);
        check_eq({tag, "_done_lag"}, done_cyc, last_hs_cyc + 1);
        check_eq({tag, "_q_empty"}, beat_q.size() + iss_q.size(), 32'd0);
        check_eq({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int h0;
        int d0;
        int busy_low;
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        param_x_last = '0;
        param_y_last = '0;
        m_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_done", {31'b0, done}, 32'd0);
        check_eq("rst_calc_valid", {31'b0, calc_valid}, 32'd0);
        check_eq("rst_m_flags", {29'b0, m_valid, m_eol, m_last}, 32'd0);
        check_eq("rst_cke", {31'b0, cke}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        step();

`ifndef JELLY_RASTERIZER_SCAN_CTL_CONTINUOUS_EN
        // 1: basic 4x2 frame
        run_frame("t1", 3, 1);

        // 2: same frame under alternating back-pressure
        toggle_ready = 1'b1;
        run_frame("t2", 3, 1);
        toggle_ready = 1'b0;
        m_ready = 1'b1;

        // 3: single-pixel frame
        run_frame("t3", 0, 0);
        // degenerate single column
        run_frame("t3col", 0, 2);

        // 4: abort together with start after 3 beats
        h0 = hs_cnt;
        d0 = done_cnt;
        pulse_start(3, 1);
        for (int i = 0; i < 50 && (hs_cnt - h0) < 3; i++) step();
        check_eq("t4_reach3", hs_cnt - h0, 32'd3);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check_eq("t4_busy", {31'b0, busy}, 32'd0);
        check_eq("t4_m_valid", {31'b0, m_valid}, 32'd0);
        check_eq("t4_calc_valid", {31'b0, calc_valid}, 32'd0);
        iss_q.delete();
        beat_q.delete();
        h0 = hs_cnt;
        repeat (5) step();
        check_eq("t4_no_done", done_cnt - d0, 32'd0);
        check_eq("t4_quiet", hs_cnt - h0, 32'd0);
        run_frame("t4_next", 3, 1);

        // 5: async reset mid-frame while stalled
        m_ready = 1'b0;
        pulse_start(3, 1);
        repeat (3) step();
        check_eq("t5_stalled", {30'b0, m_valid, cke}, 32'b10);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_busy", {31'b0, busy}, 32'd0);
        check_eq("t5_m_valid", {31'b0, m_valid}, 32'd0);
        check_eq("t5_calc_valid", {31'b0, calc_valid}, 32'd0);
        check_eq("t5_cke", {31'b0, cke}, 32'd1);
        iss_q.delete();
        beat_q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        busy_low = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!busy && !calc_valid) busy_low++;
        end
        check_eq("t5_idle", busy_low, 32'd5);
        run_frame("t5_next", 1, 2);
`else
        // 6: back-to-back frames
        h0 = hs_cnt;
        d0 = done_cnt;
        push_frame(1, 1);
        push_frame(1, 1);
        push_frame(1, 1);
        param_x_last = XW'(1);
        param_y_last = YW'(1);
        start = 1'b1;
        step();
        start = 1'b0;
        busy_low = 0;
        for (int i = 0; i < 100 && (done_cnt - d0) < 2; i++) begin
            step();
            if (!busy) busy_low++;
        end
        check_eq("t6_two_done", done_cnt - d0, 32'd2);
        check_eq("t6_beats", hs_cnt - h0, 32'd8);
        check_eq("t6_no_idle", busy_low, 32'd0);
        check_eq("t6_busy", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("t6_abort_busy", {31'b0, busy}, 32'd0);
        iss_q.delete();
        beat_q.delete();
        repeat (3) step();
        check_eq("t6_abort_quiet", {30'b0, busy, m_valid}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
